// File: rtl/quadram_arbiter_if.sv
// Requester-side bus of the quad-RAM arbiter: two requesters packed side by
// side (requester i owns slice i of every vector).
interface quadram_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [7:0]  we;
  logic [21:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;

  modport master (
    output req, wr, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wr, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/quadram_arbiter.sv
// Two-requester round-robin arbiter in front of a 2048x32 single-port RAM.
// Grants are combinational and complete in the granted cycle; reads return
// one cycle later. Optional bulk zero-fill sweep compiled in with the macro
// QUADRAM_ARB_CLEAR_EN; without it clr_start is ignored and clr_busy is 0.
module quadram_arbiter (
  input  logic              clk,
  input  logic              rst,
  quadram_arbiter_if.slave  bus,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [3:0]        ram_we,
  output logic [10:0]       ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  logic        last;      // 1 = requester 1 was served most recently
  logic        clearing;
  logic [10:0] clr_cnt;
  logic [1:0]  gnt_c;
  logic        sel;
  logic [1:0]  rvalid_q;

`ifdef QUADRAM_ARB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t      state, state_nxt;
  logic [10:0] cnt_nxt;

  // State register and sweep address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= cnt_nxt;
    end
  end

  // Enter the sweep on clr_start; leave after writing the last word.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = clr_cnt + 11'd1;
        if (clr_cnt == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clearing = (state == CLEAR);
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clearing         = 1'b0;
  assign clr_cnt          = '0;
`endif

  assign clr_busy = clearing;

  // One-hot grant: lone requester wins, on conflict the one not served last.
  always_comb begin
    gnt_c = '0;
    if (!rst && !clearing) begin
      case (bus.req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = last ? 2'b01 : 2'b10;
        default: gnt_c = '0;
      endcase
    end
  end

  assign sel     = gnt_c[1];
  assign bus.gnt = gnt_c;

  // RAM port mux: sweep write, granted requester, or fully idle bus.
  always_comb begin
    ram_en   = 1'b0;
    ram_wr   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst && clearing) begin
      ram_en   = 1'b1;
      ram_wr   = 1'b1;
      ram_we   = '1;
      ram_addr = clr_cnt;
    end else if (|gnt_c) begin
      ram_en   = 1'b1;
      ram_wr   = bus.wr[sel];
      ram_addr = sel ? bus.addr[21:11]  : bus.addr[10:0];
      ram_din  = sel ? bus.wdata[63:32] : bus.wdata[31:0];
      if (bus.wr[sel]) ram_we = sel ? bus.we[7:4] : bus.we[3:0];
    end
  end

  // Round-robin pointer and one-cycle read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      rvalid_q <= '0;
    end else begin
      if (|gnt_c) last <= sel;
      rvalid_q <= gnt_c & ~bus.wr;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = (|rvalid_q) ? ram_dout : '0;

endmodule

// File: tb/tb_quadram_arbiter.sv
// Self-checking bench for quadram_arbiter: a behavioural memory/arbitration
// model predicts every RAM-bus cycle and queues expected read returns that a
// separate monitor consumes. Honours QUADRAM_ARB_CLEAR_EN like the design.
module tb_quadram_arbiter;

`ifdef QUADRAM_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_start = 1'b0;
  logic        clr_busy, ram_en, ram_wr;
  logic [3:0]  ram_we;
  logic [10:0] ram_addr;
  logic [31:0] ram_din, ram_dout;

  quadram_arbiter_if bus();

  quadram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    logic [31:0] v;
    v = 32'(i);
    if (i == 2047) return '0;
    return (v * 32'h9E3779B1) ^ 32'hA5C30F17;
  endfunction

  // RAM attached to the DUT's RAM port.
  logic [31:0] bram [2048];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 2048; i++) bram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_wr) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) bram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= bram[ram_addr];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state.
  typedef struct { int who; logic [31:0] data; int cyc; } rd_t;
  rd_t         sbq[$];
  logic [31:0] mmem [2048];
  bit          m_clear;
  int          m_cnt;
  int          m_last;

  bit          p_req [2];
  bit          p_wr  [2];
  logic [3:0]  p_we  [2];
  logic [10:0] p_addr[2];
  logic [31:0] p_wdata[2];

  task automatic set_req(input int k, input bit w, input logic [3:0] be,
                         input logic [10:0] a, input logic [31:0] d);
    p_req[k] = 1'b1; p_wr[k] = w; p_we[k] = be; p_addr[k] = a; p_wdata[k] = d;
  endtask

  // One clock: drive, then compare the combinational RAM bus with the model.
  task automatic step(input bit do_rst, input bit do_clr);
    int          k;
    logic [1:0]  e_gnt;
    logic        e_en, e_wr;
    logic [3:0]  e_we;
    logic [10:0] e_addr;
    logic [31:0] e_din;
    @(posedge clk);
    #1;
    rst        = do_rst;
    clr_start  = do_clr;
    bus.req    = {p_req[1], p_req[0]};
    bus.wr     = {p_wr[1], p_wr[0]};
    bus.we     = {p_we[1], p_we[0]};
    bus.addr   = {p_addr[1], p_addr[0]};
    bus.wdata  = {p_wdata[1], p_wdata[0]};
    #2;
    if (do_rst) begin
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_ram_en", 32'(ram_en), 32'h0);
      check("rst_ram_wr", 32'(ram_wr), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      m_clear = 1'b0; m_cnt = 0; m_last = 1;
      return;
    end
    check("clr_busy", 32'(clr_busy), 32'(m_clear));
    e_gnt = '0; e_en = 1'b0; e_wr = 1'b0; e_we = '0; e_addr = '0; e_din = '0;
    if (m_clear) begin
      e_en = 1'b1; e_wr = 1'b1; e_we = 4'hF; e_addr = 11'(m_cnt);
      mmem[m_cnt] = '0;
      if (m_cnt == 2047) m_clear = 1'b0;
      m_cnt++;
    end else begin
      k = -1;
      if (p_req[0] && p_req[1]) k = (m_last == 1) ? 0 : 1;
      else if (p_req[0])        k = 0;
      else if (p_req[1])        k = 1;
      if (do_clr && CLEAR_EN) begin m_clear = 1'b1; m_cnt = 0; end
      if (k >= 0) begin
        e_gnt  = (k == 0) ? 2'b01 : 2'b10;
        e_en   = 1'b1;
        e_wr   = p_wr[k];
        e_addr = p_addr[k];
        e_din  = p_wdata[k];
        if (p_wr[k]) begin
          e_we = p_we[k];
          for (int b = 0; b < 4; b++)
            if (p_we[k][b]) mmem[p_addr[k]][8*b +: 8] = p_wdata[k][8*b +: 8];
        end else begin
          sbq.push_back('{who: k, data: mmem[p_addr[k]], cyc: cyc + 1});
        end
        m_last   = k;
        p_req[k] = 1'b0;
      end
    end
    check("gnt", 32'(bus.gnt), 32'(e_gnt));
    check("ram_en", 32'(ram_en), 32'(e_en));
    check("ram_wr", 32'(ram_wr), 32'(e_wr));
    check("ram_we", 32'(ram_we), 32'(e_we));
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_din", ram_din, e_din);
  endtask

  task automatic drain();
    for (int t = 0; t < 4 && (p_req[0] || p_req[1]); t++) step(1'b0, 1'b0);
    check("drain", 32'({p_req[1], p_req[0]}), 32'h0);
  endtask

  // Read-return monitor: every rvalid must match the oldest queued read.
  always @(negedge clk) begin
    rd_t e;
    if (bus.rvalid === 2'b00) begin
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        check("rvalid_missing", 32'(bus.rvalid), 32'(2'b01 << e.who));
      end
    end else if (sbq.size() == 0) begin
      check("rvalid_spurious", 32'(bus.rvalid), 32'h0);
    end else begin
      e = sbq.pop_front();
      check("rvalid_who", 32'(bus.rvalid), 32'(2'b01 << e.who));
      check("rdata", bus.rdata, e.data);
      check("read_latency", 32'(cyc), 32'(e.cyc));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          nb;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) mmem[i] = init_val(i);
    for (int k = 0; k < 2; k++) begin
      p_req[k] = 1'b0; p_wr[k] = 1'b0; p_we[k] = '0; p_addr[k] = '0; p_wdata[k] = '0;
    end
    m_clear = 1'b0; m_cnt = 0; m_last = 1;
    bus.req = '0; bus.wr = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

    repeat (3) step(1'b1, 1'b0);

    // Both requesting right after reset: requester 0 wins first, then alternate.
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b0, 4'h0, 11'h010, 32'h0);
      set_req(1, 1'b0, 4'h0, 11'h020, 32'h0);
      step(1'b0, 1'b0);
      check("rr_seq", 32'(bus.gnt), (t % 2 == 0) ? 32'h1 : 32'h2);
    end
    drain();

    // Single read, same-cycle grant with byte enables suppressed.
    set_req(0, 1'b0, 4'hF, 11'h205, 32'h0);
    step(1'b0, 1'b0);
    check("single_gnt", 32'(bus.gnt), 32'h1);
    check("single_addr", 32'(ram_addr), 32'h205);
    check("single_we", 32'(ram_we), 32'h0);
    step(1'b0, 1'b0);

    // Partial write then read back from the top word.
    set_req(1, 1'b1, 4'b0011, 11'h7FF, 32'hCAFEF00D);
    step(1'b0, 1'b0);
    set_req(1, 1'b0, 4'h0, 11'h7FF, 32'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("partial_rd_valid", 32'(bus.rvalid), 32'h2);
    check("partial_rd_data", bus.rdata, 32'h0000F00D);

`ifdef QUADRAM_ARB_CLEAR_EN
    // Full sweep with both requesters blocked until it finishes.
    repeat (2) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    set_req(0, 1'b0, 4'h0, 11'd5, 32'h0);
    set_req(1, 1'b0, 4'h0, 11'd6, 32'h0);
    nb = 0;
    for (int t = 0; t < 2100; t++) begin
      step(1'b0, 1'b0);
      if (clr_busy !== 1'b1) break;
      nb++;
    end
    check("clr_len", 32'(nb), 32'd2048);
    check("post_clr_gnt", 32'(bus.gnt), 32'h1);
    drain();

    set_req(0, 1'b1, 4'hF, 11'd100, 32'h12345678);
    step(1'b0, 1'b0);
    set_req(0, 1'b1, 4'hF, 11'd50, 32'h12345678);
    step(1'b0, 1'b0);

    // Read granted alongside clr_start, then reset aborts the sweep at word 100.
    set_req(0, 1'b0, 4'h0, 11'd50, 32'h0);
    step(1'b0, 1'b1);
    check("clr_start_gnt", 32'(bus.gnt), 32'h1);
    repeat (100) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("abort_busy", 32'(clr_busy), 32'h0);
    check("abort_en", 32'(ram_en), 32'h0);
    set_req(0, 1'b0, 4'h0, 11'd50, 32'h0);
    step(1'b0, 1'b0);
    set_req(0, 1'b0, 4'h0, 11'd99, 32'h0);
    step(1'b0, 1'b0);
    set_req(0, 1'b0, 4'h0, 11'd100, 32'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`else
    // clr_start has no effect on grants or clr_busy.
    set_req(0, 1'b0, 4'h0, 11'h003, 32'h0);
    step(1'b0, 1'b1);
    check("noclr_gnt", 32'(bus.gnt), 32'h1);
    repeat (3) begin
      step(1'b0, 1'b0);
      check("noclr_busy", 32'(clr_busy), 32'h0);
    end
`endif

    // Randomized traffic, biased toward a few hot addresses.
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_req[k] && $urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 1) == 1) a = 11'($urandom_range(0, 15));
          else                           a = 11'($urandom);
          set_req(k, 1'($urandom), 4'($urandom), a, $urandom);
        end
      end
      step(1'b0, CLEAR_EN ? 1'b0 : 1'($urandom));
    end
    drain();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
